// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - RV32I operand-select stage with two-level bypass and 2-entry skid buffer
//
// Purpose:
//   Accepts one decoded instruction per cycle (valid/ready).
//   Resolves rs1/rs2 through an execute/writeback bypass.
//   Selects the A/B function-unit operands by instruction type.
//   Holds results in a two-entry FIFO skid buffer. in_ready and all out_* come
//   from registered state only.
//
// Configuration macro: OPSTAGE_FWD_EN
//   defined   : rs resolves through the execute bypass, then the writeback
//               bypass, then the regfile.
//   undefined : rs resolves to (rs==0) ? 0 : regfile data; the byp_* ports
//               are ignored.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready        upstream handshake
//   in_type/fun3/fun7/rd/    decoded instruction fields
//     rs1/rs2/pc/imm
//   rf_dout0/rf_dout1        regfile read data for in_rs1/in_rs2
//   byp_{ex,wb}_{we,rd,data} bypass sources (execute has priority)
//   flush                    synchronous kill of buffered and incoming entries
//   out_valid/out_ready      downstream handshake
//   out_a/out_b/out_rs2      selected operands and resolved rs2
//   out_type/fun3/fun7/rd    forwarded instruction fields
//   out_illegal              in_type was outside 0..8

module operand_stage #(
    parameter int XLEN   = 32,
    parameter int RADDR  = 5,
    parameter int PC_INC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_type,
    input  logic [2:0]       in_fun3,
    input  logic             in_fun7,
    input  logic [RADDR-1:0] in_rd,
    input  logic [RADDR-1:0] in_rs1,
    input  logic [RADDR-1:0] in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  rf_dout0,
    input  logic [XLEN-1:0]  rf_dout1,
    input  logic             byp_ex_we,
    input  logic             byp_wb_we,
    input  logic [RADDR-1:0] byp_ex_rd,
    input  logic [RADDR-1:0] byp_wb_rd,
    input  logic [XLEN-1:0]  byp_ex_data,
    input  logic [XLEN-1:0]  byp_wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [XLEN-1:0]  out_rs2,
    output logic [3:0]       out_type,
    output logic [2:0]       out_fun3,
    output logic             out_fun7,
    output logic [RADDR-1:0] out_rd,
    output logic             out_illegal
);

    localparam logic [3:0] T_LOAD  = 4'd0;
    localparam logic [3:0] T_IMM   = 4'd1;
    localparam logic [3:0] T_STORE = 4'd2;
    localparam logic [3:0] T_REG   = 4'd3;
    localparam logic [3:0] T_LUI   = 4'd4;
    localparam logic [3:0] T_AUIPC = 4'd5;
    localparam logic [3:0] T_BRNCH = 4'd6;
    localparam logic [3:0] T_JALR  = 4'd7;
    localparam logic [3:0] T_JAL   = 4'd8;

    typedef struct packed {
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [XLEN-1:0]  rs2;
        logic [3:0]       typ;
        logic [2:0]       fun3;
        logic             fun7;
        logic [RADDR-1:0] rd;
        logic             illegal;
    } entry_t;

    entry_t     mem [2];
    logic       head;
    logic [1:0] count;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    entry_t          new_entry;
    logic            push;
    logic            pop;
    logic            tail;

    // ------------------------------------------------------------------
    // Source resolve
    // ------------------------------------------------------------------
`ifdef OPSTAGE_FWD_EN
    always_comb begin
        rs1_val = rf_dout0;
        if (in_rs1 == '0)
            rs1_val = '0;
        else if (byp_ex_we && byp_ex_rd == in_rs1)
            rs1_val = byp_ex_data;
        else if (byp_wb_we && byp_wb_rd == in_rs1)
            rs1_val = byp_wb_data;
    end

    always_comb begin
        rs2_val = rf_dout1;
        if (in_rs2 == '0)
            rs2_val = '0;
        else if (byp_ex_we && byp_ex_rd == in_rs2)
            rs2_val = byp_ex_data;
        else if (byp_wb_we && byp_wb_rd == in_rs2)
            rs2_val = byp_wb_data;
    end
`else
    // The bypass inputs stay on the port list so both builds share one
    // wrapper. They are reduced here only to keep them visibly consumed.
    logic unused_byp;
    assign unused_byp = ^{byp_ex_we, byp_wb_we, byp_ex_rd, byp_wb_rd,
                          byp_ex_data, byp_wb_data};

    assign rs1_val = (in_rs1 == '0) ? '0 : rf_dout0;
    assign rs2_val = (in_rs2 == '0) ? '0 : rf_dout1;
`endif

    // ------------------------------------------------------------------
    // Operand select
    // ------------------------------------------------------------------
    always_comb begin
        new_entry         = '0;
        new_entry.typ     = in_type;
        new_entry.fun3    = in_fun3;
        new_entry.fun7    = in_fun7;
        new_entry.rd      = in_rd;
        new_entry.rs2     = rs2_val;
        new_entry.illegal = 1'b0;
        unique case (in_type)
            T_LOAD, T_IMM, T_STORE: begin
                new_entry.a = rs1_val;
                new_entry.b = in_imm;
            end
            T_REG, T_BRNCH: begin
                new_entry.a = rs1_val;
                new_entry.b = rs2_val;
            end
            T_LUI: begin
                new_entry.a = '0;
                new_entry.b = in_imm;
            end
            T_AUIPC: begin
                new_entry.a = in_pc;
                new_entry.b = in_imm;
            end
            T_JALR, T_JAL: begin
                new_entry.a = in_pc;
                new_entry.b = XLEN'(PC_INC);
            end
            default: begin
                // Illegal types still flow, so downstream sees them in order.
                new_entry.a       = '1;
                new_entry.b       = '1;
                new_entry.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready;
    // Free slot follows the head. When count==1, a pop in the same cycle
    // moves head onto the other slot, which is exactly the slot written.
    assign tail = head ^ count[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 2'd0;
            head  <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
        end else begin
            if (pop)
                head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push) begin
            mem[tail] <= new_entry;
        end
    end

    assign out_a       = mem[head].a;
    assign out_b       = mem[head].b;
    assign out_rs2     = mem[head].rs2;
    assign out_type    = mem[head].typ;
    assign out_fun3    = mem[head].fun3;
    assign out_fun7    = mem[head].fun7;
    assign out_rd      = mem[head].rd;
    assign out_illegal = mem[head].illegal;

endmodule

// File: tb/tb_operand_stage.sv
// tb/tb_operand_stage.sv - self-checking bench for operand_stage
module tb_operand_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_type = '0;
    logic [2:0]  in_fun3 = '0;
    logic        in_fun7 = 1'b0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_pc = '0, in_imm = '0;
    logic [31:0] rf_dout0 = '0, rf_dout1 = '0;
    logic        byp_ex_we = 1'b0, byp_wb_we = 1'b0;
    logic [4:0]  byp_ex_rd = '0, byp_wb_rd = '0;
    logic [31:0] byp_ex_data = '0, byp_wb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_a, out_b, out_rs2;
    logic [3:0]  out_type;
    logic [2:0]  out_fun3;
    logic        out_fun7;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    operand_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_fun3(in_fun3), .in_fun7(in_fun7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_pc(in_pc), .in_imm(in_imm),
        .rf_dout0(rf_dout0), .rf_dout1(rf_dout1),
        .byp_ex_we(byp_ex_we), .byp_wb_we(byp_wb_we),
        .byp_ex_rd(byp_ex_rd), .byp_wb_rd(byp_wb_rd),
        .byp_ex_data(byp_ex_data), .byp_wb_data(byp_wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_rs2(out_rs2),
        .out_type(out_type), .out_fun3(out_fun3), .out_fun7(out_fun7),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  typ;
        logic [4:0]  rs1, rs2;
        logic [31:0] rf0, rf1, pc, imm;
        logic        ex_we, wb_we;
        logic [4:0]  ex_rd, wb_rd;
        logic [31:0] ex_data, wb_data;
        logic [31:0] exp_a, exp_b, exp_rs2;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input vec_t v, input logic [4:0] rd);
        in_type     = v.typ;  in_rs1 = v.rs1;  in_rs2 = v.rs2;
        rf_dout0    = v.rf0;  rf_dout1 = v.rf1;
        in_pc       = v.pc;   in_imm = v.imm;  in_rd = rd;
        in_fun3     = rd[2:0]; in_fun7 = rd[0];
        byp_ex_we   = v.ex_we; byp_ex_rd = v.ex_rd; byp_ex_data = v.ex_data;
        byp_wb_we   = v.wb_we; byp_wb_rd = v.wb_rd; byp_wb_data = v.wb_data;
    endtask

    function automatic vec_t mk(input logic [3:0] typ, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] rf0, input logic [31:0] rf1,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic [31:0] ers2, input logic eill);
        vec_t v;
        v.typ = typ; v.rs1 = rs1; v.rs2 = rs2; v.rf0 = rf0; v.rf1 = rf1;
        v.pc = pc; v.imm = imm;
        v.ex_we = 1'b0; v.wb_we = 1'b0; v.ex_rd = '0; v.wb_rd = '0;
        v.ex_data = '0; v.wb_data = '0;
        v.exp_a = ea; v.exp_b = eb; v.exp_rs2 = ers2; v.exp_ill = eill;
        return v;
    endfunction

    task automatic push_imm(input logic [31:0] imm, input logic [4:0] rd);
        vec_t v;
        v = mk(4'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, imm, 32'h0, imm, 32'h0, 1'b0);
        set_vec(v, rd);
        in_valid = 1'b1;
    endtask

    initial begin
        logic fwd;
`ifdef OPSTAGE_FWD_EN
        fwd = 1'b1;
`else
        fwd = 1'b0;
`endif
        //            typ   rs1 rs2 rf0           rf1         pc          imm           exp_a         exp_b         exp_rs2      ill
        vecs[0]  = mk(4'd3, 1, 2, 32'd5,        32'd7,      32'h0,      32'h0,        32'd5,        32'd7,        32'd7,       0);
        vecs[1]  = mk(4'd8, 0, 2, 32'h9,        32'd7,      32'h100,    32'h0,        32'h100,      32'd4,        32'd7,       0);
        vecs[2]  = mk(4'd4, 1, 0, 32'h9,        32'h9,      32'h0,      32'h12345000, 32'h0,        32'h12345000, 32'h0,       0);
        vecs[3]  = mk(4'd2, 4, 5, 32'h1000,     32'hAB,     32'h0,      32'h10,       32'h1000,     32'h10,       32'hAB,      0);
        vecs[4]  = mk(4'd12,1, 2, 32'h1,        32'h2,      32'h0,      32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2,       1);
        // rs1=3 with both bypasses hitting: execute wins
        vecs[5]  = mk(4'd1, 3, 0, 32'h33,       32'h0,      32'h0,      32'h4,        fwd ? 32'h11 : 32'h33, 32'h4, 32'h0, 0);
        vecs[5].ex_we = 1; vecs[5].ex_rd = 3; vecs[5].ex_data = 32'h11;
        vecs[5].wb_we = 1; vecs[5].wb_rd = 3; vecs[5].wb_data = 32'h22;
        // execute dropped: writeback wins
        vecs[6]  = mk(4'd1, 3, 0, 32'h33,       32'h0,      32'h0,      32'h4,        fwd ? 32'h22 : 32'h33, 32'h4, 32'h0, 0);
        vecs[6].wb_we = 1; vecs[6].wb_rd = 3; vecs[6].wb_data = 32'h22;
        // x0 never bypasses
        vecs[7]  = mk(4'd3, 0, 0, 32'h55,       32'h66,     32'h0,      32'h0,        32'h0,        32'h0,        32'h0,       0);
        vecs[7].ex_we = 1; vecs[7].ex_rd = 0; vecs[7].ex_data = 32'h9;
        vecs[8]  = mk(4'd5, 1, 0, 32'h9,        32'h0,      32'h200,    32'h3000,     32'h200,      32'h3000,     32'h0,       0);
        vecs[9]  = mk(4'd7, 1, 0, 32'h9,        32'h0,      32'h300,    32'h8,        32'h300,      32'd4,        32'h0,       0);
        vecs[10] = mk(4'd6, 1, 2, 32'd8,        32'd9,      32'h0,      32'h0,        32'd8,        32'd9,        32'd9,       0);
        // rs2 via writeback while execute targets another register
        vecs[11] = mk(4'd3, 1, 6, 32'h1,        32'h60,     32'h0,      32'h0,        32'h1,        fwd ? 32'h66 : 32'h60, fwd ? 32'h66 : 32'h60, 0);
        vecs[11].ex_we = 1; vecs[11].ex_rd = 7; vecs[11].ex_data = 32'h77;
        vecs[11].wb_we = 1; vecs[11].wb_rd = 6; vecs[11].wb_data = 32'h66;
        vecs[12] = mk(4'd0, 2, 0, 32'h400,      32'h0,      32'h0,      32'hFFFFFFFC, 32'h400,      32'hFFFFFFFC, 32'h0,       0);

        // Reset held with in_valid asserted
        rst = 1'b0;
        set_vec(vecs[0], 5'd1);
        in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_a",     out_a, 32'd0);
        chk("rst_out_b",     out_b, 32'd0);
        chk("rst_illegal",   {31'd0, out_illegal}, 32'd0);
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Table: streaming with out_ready high, one entry in flight each cycle
        for (int i = 0; i < 13; i++) begin
            set_vec(vecs[i], 5'(i + 1));
            in_valid = 1'b1;
            step();
            // Later bypass changes must not alter the captured entry
            byp_ex_we = 1'b1; byp_ex_rd = vecs[i].rs1; byp_ex_data = 32'hDEAD0000;
            rf_dout0 = 32'hBEEF0000;
            #1;
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_a", i),     out_a,   vecs[i].exp_a);
            chk($sformatf("v%0d_b", i),     out_b,   vecs[i].exp_b);
            chk($sformatf("v%0d_rs2", i),   out_rs2, vecs[i].exp_rs2);
            chk($sformatf("v%0d_ill", i),   {31'd0, out_illegal}, {31'd0, vecs[i].exp_ill});
            chk($sformatf("v%0d_type", i),  {28'd0, out_type}, {28'd0, vecs[i].typ});
            chk($sformatf("v%0d_rd", i),    {27'd0, out_rd}, 32'(i + 1));
            chk($sformatf("v%0d_fun3", i),  {29'd0, out_fun3}, 32'((i + 1) % 8));
            chk($sformatf("v%0d_rdy", i),   {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        byp_ex_we = 1'b0;
        step();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Back-pressure: fill both slots, hold I3, then drain in order
        out_ready = 1'b0;
        push_imm(32'hA1, 5'd1);
        step();
        chk("bp_rdy_c1", {31'd0, in_ready}, 32'd1);
        push_imm(32'hA2, 5'd2);
        step();
        chk("bp_rdy_c2", {31'd0, in_ready}, 32'd0);
        chk("bp_head1",  out_b, 32'hA1);
        push_imm(32'hA3, 5'd3);
        step();
        chk("bp_hold_rdy",  {31'd0, in_ready}, 32'd0);
        chk("bp_hold_head", out_b, 32'hA1);
        out_ready = 1'b1;
        step();
        chk("bp_pop1_rdy",  {31'd0, in_ready}, 32'd1);
        chk("bp_head2",     out_b, 32'hA2);
        chk("bp_head2_rd",  {27'd0, out_rd}, 32'd2);
        step();
        in_valid = 1'b0;
        chk("bp_head3",     out_b, 32'hA3);
        chk("bp_head3_rd",  {27'd0, out_rd}, 32'd3);
        step();
        chk("bp_empty",     {31'd0, out_valid}, 32'd0);

        // Flush with two entries buffered and a push presented
        out_ready = 1'b0;
        push_imm(32'hB1, 5'd4);
        step();
        push_imm(32'hB2, 5'd5);
        step();
        chk("fl_full", {31'd0, in_ready}, 32'd0);
        push_imm(32'hB3, 5'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl2_valid", {31'd0, out_valid}, 32'd0);
        chk("fl2_rdy",   {31'd0, in_ready},  32'd1);
        step();
        chk("fl2_absent", {31'd0, out_valid}, 32'd0);

        // Flush with one entry buffered: the accept-capable push is dropped
        push_imm(32'hC1, 5'd7);
        step();
        chk("fl1_pre", {31'd0, out_valid}, 32'd1);
        push_imm(32'hC2, 5'd8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl1_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("fl1_absent", {31'd0, out_valid}, 32'd0);
        push_imm(32'hD1, 5'd9);
        step();
        in_valid = 1'b0;
        chk("post_fl_b", out_b, 32'hD1);

        // Reset mid-transfer discards buffered entries
        push_imm(32'hE1, 5'd10);
        step();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_b",     out_b, 32'd0);
        rst = 1'b1;
        step();
        chk("arst_after", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
